// File: rtl/io_input_conditioner_pkg.sv
// Shared constants for the board input-conditioning stage and the I/O decoder
// that reads its status word.
package io_input_conditioner_pkg;

  // 10 ms of stable level at the 100 MHz board clock.
  localparam int DEBOUNCE_CYCLES_DEFAULT = 1_000_000;

  // Bit positions of the sticky request flags in the decoder's status word.
  localparam int STAT_L_BIT = 1;
  localparam int STAT_R_BIT = 0;

  // Width of a counter that must reach n-1; never narrower than one bit.
  function automatic int cnt_width(input int n);
    return (n > 2) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/debouncer.sv
// One push-button: two-flop synchroniser, stability counter and a registered
// one-cycle rise pulse for each accepted 0->1 change of the debounced level.
module debouncer
  import io_input_conditioner_pkg::*;
#(
  parameter int DEBOUNCE_CYCLES = DEBOUNCE_CYCLES_DEFAULT
) (
  input  logic clk,
  input  logic reset_n,
  input  logic raw,
  output logic level,
  output logic rise
);

  localparam int              CW       = cnt_width(DEBOUNCE_CYCLES);
  localparam logic [CW-1:0]   CNT_LAST = CW'(DEBOUNCE_CYCLES - 1);

  logic          sync_q1;
  logic          sync_q2;
  logic [CW-1:0] cnt;

  // Bring the asynchronous button onto clk before anything looks at it.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      sync_q1 <= 1'b0;
      sync_q2 <= 1'b0;
    end else begin
      // NOTE: non-blocking assignments make sync_q2 take the old sync_q1,
      // giving two real flop stages; blocking would collapse them into one.
      sync_q1 <= raw;
      sync_q2 <= sync_q1;
    end
  end

  // Accept a new level only after it has differed for DEBOUNCE_CYCLES
  // consecutive cycles; any matching cycle restarts the count.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      cnt   <= '0;
      level <= 1'b0;
      rise  <= 1'b0;
    end else begin
      rise <= 1'b0;
      if (sync_q2 == level) begin
        cnt <= '0;
      end else if (cnt == CNT_LAST) begin
        cnt   <= '0;
        level <= ~level;
        rise  <= ~level;
      end else begin
        cnt <= cnt + CW'(1);
      end
    end
  end

endmodule

// File: rtl/io_input_conditioner.sv
// Input conditioning ahead of the memory-mapped I/O decoder: synchronised
// switches, debounced buttons, sticky press flags and a switch snapshot taken
// on each accepted right-button press.
module io_input_conditioner
  import io_input_conditioner_pkg::*;
#(
  parameter int DEBOUNCE_CYCLES = DEBOUNCE_CYCLES_DEFAULT,
  parameter int SW_WIDTH        = 16
) (
  input  logic                clk,
  input  logic                reset_n,
  input  logic                btn_l,
  input  logic                btn_r,
  input  logic [SW_WIDTH-1:0] sw,
  input  logic                clr_l,
  input  logic                clr_r,
  output logic                btn_l_db,
  output logic                btn_r_db,
  output logic                l_flag,
  output logic                r_flag,
  output logic [SW_WIDTH-1:0] sw_sync,
  output logic [SW_WIDTH-1:0] sw_snap
);

  logic                rise_l;
  logic                rise_r;
  logic [SW_WIDTH-1:0] sw_q1;

  debouncer #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_db_l (
    .clk     (clk),
    .reset_n (reset_n),
    .raw     (btn_l),
    .level   (btn_l_db),
    .rise    (rise_l)
  );

  debouncer #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_db_r (
    .clk     (clk),
    .reset_n (reset_n),
    .raw     (btn_r),
    .level   (btn_r_db),
    .rise    (rise_r)
  );

  // Two-flop synchroniser for the live switch bank.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      sw_q1   <= '0;
      sw_sync <= '0;
    end else begin
      sw_q1   <= sw;
      sw_sync <= sw_q1;
    end
  end

  // Sticky request flags: a press sets, a decoder pulse clears, and a press
  // arriving together with a clear wins so it is never lost.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      l_flag <= 1'b0;
      r_flag <= 1'b0;
    end else begin
      if (rise_l)     l_flag <= 1'b1;
      else if (clr_l) l_flag <= 1'b0;
      if (rise_r)     r_flag <= 1'b1;
      else if (clr_r) r_flag <= 1'b0;
    end
  end

  // Freeze the switches on each accepted right press so the CPU reads a
  // value that does not move under the operator's hands.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      sw_snap <= '0;
    end else if (rise_r) begin
      sw_snap <= sw_sync;
    end
  end

endmodule

// File: doc/io_input_conditioner.md
# io_input_conditioner

Input-conditioning stage directly upstream of the memory-mapped I/O decoder in the multi-cycle MIPS FPGA system. It synchronises the 16 board switches, debounces the left and right push-buttons, and converts each press into a sticky request flag. The decoder exposes these flags as a status word and clears them with one-cycle pulses. It also captures a switch snapshot on every right-button press, so the CPU reads a value that stays stable while the operator moves switches.

## Interface
Parameters:
- DEBOUNCE_CYCLES, 1_000_000: consecutive stable cycles required to accept a button level change (10 ms at 100 MHz); legal range ≥2.
- SW_WIDTH, 16: number of switch inputs.

Ports:
- clk  in  1  system clock (100 MHz board clock).
- reset_n  in  1  asynchronous, active-low reset.
- btn_l  in  1  raw left button, asynchronous, active-high.
- btn_r  in  1  raw right button, asynchronous, active-high.
- sw  in  SW_WIDTH  raw switches, asynchronous.
- clr_l  in  1  one-cycle pulse from decoder: clear l_flag.
- clr_r  in  1  one-cycle pulse from decoder: clear r_flag.
- btn_l_db  out  1  debounced left level.
- btn_r_db  out  1  debounced right level.
- l_flag  out  1  sticky "left pressed" request.
- r_flag  out  1  sticky "right pressed" request.
- sw_sync  out  SW_WIDTH  two-flop-synchronised live switches.
- sw_snap  out  SW_WIDTH  switch value captured at the last accepted right press.

## Operation
- Reset (reset_n low, asynchronous): all synchroniser flops, counters, debounced levels, rise pulses, flags, sw_sync and sw_snap go to 0. Outputs stay 0 until the first clk edge after deassertion.
- Every raw input passes through a two-flop synchroniser. No logic samples raw inputs directly.
- Debounce, per button:
  - State is `stable` (the debounced level) plus a counter of width clog2(DEBOUNCE_CYCLES).
  - When the synchronised level equals `stable`, the counter resets to 0.
  - When they differ and counter == DEBOUNCE_CYCLES-1, `stable` toggles and the counter resets to 0.
  - When they differ otherwise, the counter increments.
  - A single matching cycle restarts the count, so glitches shorter than DEBOUNCE_CYCLES are ignored.
- Rise detect: `rise` is a registered one-cycle pulse, asserted in the cycle after `stable` goes 0→1. A 1→0 transition produces no event.
- Flags:
  - On an edge with rise=1, the flag sets. On an edge with clr=1 and rise=0, the flag clears.
  - If rise and clr occur in the same cycle, set wins so the new press is not lost.
  - clr while the flag is already 0 has no effect.
  - Repeated presses while the flag is set leave it set; presses are not counted.
- Snapshot: on the edge where right rise=1, sw_snap ← sw_sync. sw_snap holds its value otherwise and is not affected by clr_r.

## Timing
- Synchroniser latency is 2 edges: raw change → sw_sync.
- Button latency, raw press held steady from edge 0:
  - btn_*_db rises at edge DEBOUNCE_CYCLES+2.
  - rise pulse is high during the following cycle.
  - flag and sw_snap update at edge DEBOUNCE_CYCLES+3.
- Release needs the same DEBOUNCE_CYCLES+2 to lower btn_*_db.
- clr_* takes effect on the edge it is sampled; the flag reads 0 in the next cycle.
- Reset asserted mid-count discards partial counts. A press in progress must be re-held a full DEBOUNCE_CYCLES after reset release.

## Structure
- The shared package holds DEBOUNCE_CYCLES_DEFAULT and the status-word bit positions used by the decoder: STAT_L_BIT=1, STAT_R_BIT=0.
- One sub-module, `debouncer` (parameter DEBOUNCE_CYCLES; ports clk, reset_n, raw, level, rise). It contains synchroniser, counter and rise register, and is instantiated twice.
- The switch synchroniser, flags and snapshot register live in the top module.

## Test plan
Run with DEBOUNCE_CYCLES=4.
- Hold btn_r=1 with sw=16'hA5C3 → btn_r_db=1 at edge 6; r_flag=1 and sw_snap=16'hA5C3 at edge 7. Change sw to 16'h0001 afterwards → sw_snap stays 16'hA5C3 and sw_sync becomes 16'h0001 2 edges later.
- btn_l glitches of 1 and 3 cycles high, separated by 1 cycle low → btn_l_db and l_flag stay 0.
- l_flag=1, pulse clr_l → l_flag=0 next cycle. Press again → set again after 7 edges.
- Align clr_r with the right rise pulse → r_flag stays 1.
- Hold btn_l=1 for 3 cycles, assert reset_n=0 for 1 cycle, hold btn_l=1 another 5 cycles → no flag until a full 4-cycle stable count completes after reset. All outputs read 0 during reset.
- Hold btn_r=1 for 20 cycles, then release → exactly one rise and one snapshot. Release changes no flag.
